sad_min_tracker: RTL and testbench

Parametrised multi-lane running-minimum tracker for the SAD search path. Each beat carries LANES candidate SAD values. The block keeps the smallest SAD seen since `start`, together with the tag (window address) of the winning candidate. It is the successor to the two-lane min/tag selector and adds the following:
- generic lane count and width
- a start/last framing FSM
- a two-stage pipeline
- a held result with a done flag

It sits between the SAD datapath (MEM stage) and the register writeback of the min/tag result.

---
 rtl/sad_min_tracker.sv | 135 +++++++++++++
 tb/tb_sad_min_tracker.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_min_tracker.sv
// Multi-lane running-minimum SAD tracker with start/last framing, two-stage pipeline and held result.
// Optional early exit on a zero minimum: define SAD_EARLY_EXIT_EN.
module sad_min_tracker #(
  parameter int LANES      = 2,
  parameter int SAD_W      = 13,
  parameter int TAG_W      = 32,
  parameter int TAG_STRIDE = 256
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [LANES*SAD_W-1:0] in_sad,
  input  logic [TAG_W-1:0]       in_tag_base,
  output logic                   out_valid,
  output logic [SAD_W-1:0]       out_min,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  // Debug encoding on dbg_state: 0 IDLE, 1 SCAN, 2 DRAIN, 3 DONE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic               s1_valid;
  logic               s1_last;
  logic [SAD_W-1:0]   s1_sad;
  logic [TAG_W-1:0]   s1_tag;
  logic               last_seen;

  logic [SAD_W-1:0]   red_sad;
  logic [IDX_W-1:0]   red_idx;
  logic [TAG_W-1:0]   red_tag;
  logic               accept;
  logic               s2_hit;

  assign dbg_state = state;

  // Handshake: a beat transfers on a rising Clk edge when in_valid && in_ready; in_ready is a
  // registered decode of SCAN and never looks at in_valid. A start in the same cycle wins and the beat is dropped.
  assign accept = in_valid && in_ready && !start;
  assign s2_hit = s1_valid && (s1_sad < out_min);

  // Strict less-than scan from lane 0 upward, so the lowest index wins ties.
  always_comb begin
    red_sad = in_sad[SAD_W-1:0];
    red_idx = '0;
    for (int i = 1; i < LANES; i++) begin
      if (in_sad[i*SAD_W +: SAD_W] < red_sad) begin
        red_sad = in_sad[i*SAD_W +: SAD_W];
        red_idx = IDX_W'(i);
      end
    end
    red_tag = in_tag_base + TAG_W'(red_idx) * TAG_W'(TAG_STRIDE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_min   <= '1;
      out_tag   <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      last_seen <= 1'b0;
    end else if (start) begin
      // Fresh search or abort: flush stage 1 and re-arm the running minimum.
      state     <= SCAN;
      in_ready  <= 1'b1;
      busy      <= 1'b1;
      out_valid <= 1'b0;
      out_min   <= '1;
      out_tag   <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      last_seen <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_last  <= accept && in_last;
      if (accept) begin
        s1_sad <= red_sad;
        s1_tag <= red_tag;
      end

      if (s2_hit) begin
        out_min <= s1_sad;
        out_tag <= s1_tag;
      end

      case (state)
        SCAN: begin
          if (accept && in_last) begin
            state     <= DRAIN;
            in_ready  <= 1'b0;
            last_seen <= 1'b1;
          end
        end
        DRAIN: begin
          if (s1_valid && s1_last && last_seen) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase

`ifdef SAD_EARLY_EXIT_EN
      // A zero can never be beaten, so finish now and discard whatever is still in flight.
      if (s2_hit && (s1_sad == '0) && (state == SCAN || state == DRAIN)) begin
        state     <= DONE;
        in_ready  <= 1'b0;
        busy      <= 1'b0;
        out_valid <= 1'b1;
        s1_valid  <= 1'b0;
        s1_last   <= 1'b0;
      end
`else
`endif
    end
  end

endmodule

// File: tb/tb_sad_min_tracker.sv
// Self-checking bench for sad_min_tracker: directed scenarios plus randomized sessions,
// every cycle compared against a beat-list reference model.
module tb_sad_min_tracker;

  localparam int LANES      = 2;
  localparam int SAD_W      = 13;
  localparam int TAG_W      = 32;
  localparam int TAG_STRIDE = 256;

  logic                   Clk = 1'b0;
  logic                   Reset;
  logic                   start;
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_last;
  logic [LANES*SAD_W-1:0] in_sad;
  logic [TAG_W-1:0]       in_tag_base;
  logic                   out_valid;
  logic [SAD_W-1:0]       out_min;
  logic [TAG_W-1:0]       out_tag;
  logic                   busy;
  logic [1:0]             dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit armed       = 0;

  sad_min_tracker #(
    .LANES(LANES), .SAD_W(SAD_W), .TAG_W(TAG_W), .TAG_STRIDE(TAG_STRIDE)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_sad(in_sad), .in_tag_base(in_tag_base), .out_valid(out_valid),
    .out_min(out_min), .out_tag(out_tag), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Every beat accepted since the last start/reset, reduced to its winning lane.
  // A beat accepted in cycle a is reflected in the outputs from cycle a+2 onward.
  typedef struct {
    int               cyc;
    logic [SAD_W-1:0] sad;
    logic [TAG_W-1:0] tag;
    bit               last;
  } beat_t;

  beat_t beats[$];
  bit    session = 0;

  function automatic void lane_win(input logic [LANES*SAD_W-1:0] s, input logic [TAG_W-1:0] base,
                                   output logic [SAD_W-1:0] v, output logic [TAG_W-1:0] tg);
    logic [SAD_W-1:0] lane[LANES];
    int first;
    for (int i = 0; i < LANES; i++) lane[i] = s[i*SAD_W +: SAD_W];
    v = '1;
    for (int i = 0; i < LANES; i++) if (lane[i] < v) v = lane[i];
    first = LANES - 1;
    for (int i = LANES - 1; i >= 0; i--) if (lane[i] == v) first = i;
    tg = base + TAG_W'(first * TAG_STRIDE);
  endfunction

  function automatic void model_outputs(input int t, output logic [SAD_W-1:0] m,
                                        output logic [TAG_W-1:0] tg, output bit v,
                                        output bit rdy, output bit bsy, output logic [1:0] st);
    bit last_in = 0;
    bit zero    = 0;
    m  = '1;
    tg = '0;
    v  = 0;
    foreach (beats[i]) begin
      if (beats[i].last) last_in = 1;
      if (beats[i].cyc <= t - 2) begin
        if (beats[i].sad < m) begin
          m  = beats[i].sad;
          tg = beats[i].tag;
        end
        if (beats[i].last) v = 1;
`ifdef SAD_EARLY_EXIT_EN
        if (beats[i].sad == '0) begin
          v    = 1;
          zero = 1;
        end
`else
`endif
      end
    end
    rdy = session && !last_in && !zero;
    bsy = session && !v;
    if (!session)  st = 2'd0;
    else if (v)    st = 2'd3;
    else if (rdy)  st = 2'd1;
    else           st = 2'd2;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge Clk) begin
    logic [SAD_W-1:0] m_min, w_sad;
    logic [TAG_W-1:0] m_tag, w_tag;
    bit               m_v, m_rdy, m_busy;
    logic [1:0]       m_st;
    model_outputs(cyc, m_min, m_tag, m_v, m_rdy, m_busy, m_st);
    if (armed) begin
      check("cyc_out_min",   out_min,   m_min);
      check("cyc_out_tag",   out_tag,   m_tag);
      check("cyc_out_valid", out_valid, m_v);
      check("cyc_in_ready",  in_ready,  m_rdy);
      check("cyc_busy",      busy,      m_busy);
      check("cyc_state",     dbg_state, m_st);
    end
    if (Reset) begin
      session = 0;
      beats.delete();
      armed = 1;
    end else if (start) begin
      session = 1;
      beats.delete();
    end else if (in_valid && m_rdy) begin
      lane_win(in_sad, in_tag_base, w_sad, w_tag);
      beats.push_back('{cyc: cyc, sad: w_sad, tag: w_tag, last: in_last});
    end
    cyc++;
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  function automatic logic [LANES*SAD_W-1:0] pack2(input int a, input int b);
    return {SAD_W'(b), SAD_W'(a)};
  endfunction

  function automatic logic [SAD_W-1:0] rand_sad();
    case ($urandom_range(0, 3))
      0:       return SAD_W'($urandom_range(0, 7));
      1:       return '1;
      default: return SAD_W'($urandom());
    endcase
  endfunction

  task automatic idle(input int n);
    in_valid = 0;
    start    = 0;
    in_last  = 0;
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic pulse_start();
    start    = 1;
    in_valid = 0;
    @(posedge Clk); #1;
    start = 0;
  endtask

  task automatic pulse_reset();
    Reset    = 1;
    start    = 0;
    in_valid = 0;
    @(posedge Clk); #1;
    Reset = 0;
  endtask

  task automatic send_beat(input logic [LANES*SAD_W-1:0] s, input logic [TAG_W-1:0] base,
                           input bit last);
    int guard = 0;
    in_valid    = 1;
    in_sad      = s;
    in_tag_base = base;
    in_last     = last;
    forever begin
      @(negedge Clk);
      if (in_ready) break;
`ifdef SAD_EARLY_EXIT_EN
      if (out_valid) break;
`else
`endif
      guard++;
      if (guard > 20) begin
        check("handshake_wait", in_ready, 1);
        break;
      end
    end
    @(posedge Clk); #1;
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic wait_done();
    int guard = 0;
    forever begin
      @(negedge Clk);
      if (out_valid) break;
      guard++;
      if (guard > 50) begin
        check("done_timeout", out_valid, 1);
        break;
      end
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    Reset = 1; start = 0; in_valid = 0; in_last = 0; in_sad = '0; in_tag_base = '0;
    repeat (3) @(posedge Clk);
    #1 Reset = 0;
    @(negedge Clk);
    check("rst_out_min",   out_min,   13'h1FFF);
    check("rst_out_tag",   out_tag,   0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  0);
    check("rst_busy",      busy,      0);
    @(posedge Clk); #1;

    // Lane tie inside a beat, latency of the result
    pulse_start();
    send_beat(pack2(40, 30), 32'h100, 0);
    send_beat(pack2(25, 25), 32'h400, 0);
    send_beat(pack2(50, 60), 32'h800, 1);
    @(negedge Clk);
    check("t1_valid_early", out_valid, 0);
    @(negedge Clk);
    check("t1_valid", out_valid, 1);
    check("t1_min",   out_min,   25);
    check("t1_tag",   out_tag,   32'h400);
    @(posedge Clk); #1;

    // Equal minima across beats: earliest wins
    pulse_start();
    send_beat(pack2(10, 20), 32'h000, 0);
    send_beat(pack2(10, 20), 32'h200, 1);
    wait_done();
    check("t2_min", out_min, 10);
    check("t2_tag", out_tag, 32'h000);
    @(posedge Clk); #1;

    // Reset while draining
    pulse_start();
    send_beat(pack2(100, 120), 32'h0, 0);
    send_beat(pack2(50, 70), 32'h1000, 1);
    Reset = 1;
    @(negedge Clk);
    check("t5_in_drain", dbg_state, 2);
    @(posedge Clk); #1;
    Reset = 0;
    @(negedge Clk);
    check("t5_valid", out_valid, 0);
    check("t5_min",   out_min,   13'h1FFF);
    check("t5_tag",   out_tag,   0);
    check("t5_state", dbg_state, 0);
    check("t5_ready", in_ready,  0);
    @(posedge Clk); #1;

    // start from IDLE with a beat in the same cycle
    start = 1; in_valid = 1; in_sad = pack2(5, 5); in_tag_base = 32'h50; in_last = 0;
    @(negedge Clk);
    check("t3_ready_low", in_ready, 0);
    @(posedge Clk); #1;
    start = 0;
    send_beat(pack2(7, 9), 32'h300, 1);
    wait_done();
    check("t3_min", out_min, 7);
    check("t3_tag", out_tag, 32'h300);
    @(posedge Clk); #1;

    // Abort right after the first beat
    pulse_start();
    send_beat(pack2(3, 40), 32'h10, 0);
    pulse_start();
    send_beat(pack2(9, 11), 32'h20, 1);
    wait_done();
    check("t4_min", out_min, 9);
    check("t4_tag", out_tag, 32'h20);
    @(posedge Clk); #1;

    // Zero minimum in the middle of a search
    pulse_start();
    send_beat(pack2(4, 6), 32'h1000, 0);
    send_beat(pack2(0, 2), 32'h2000, 0);
`ifdef SAD_EARLY_EXIT_EN
    idle(1);
    send_beat(pack2(8, 8), 32'h3000, 1);
    check("t6_ready_low", in_ready,  0);
    check("t6_valid",     out_valid, 1);
`else
    send_beat(pack2(8, 8), 32'h3000, 1);
    @(negedge Clk);
    check("t6_valid_early", out_valid, 0);
    wait_done();
`endif
    check("t6_min", out_min, 0);
    check("t6_tag", out_tag, 32'h2000);
    @(posedge Clk); #1;

    // Randomized sessions, checked only by the per-cycle model
    for (int s = 0; s < 250; s++) begin
      int  n;
      bit  aborted = 0;
      if ($urandom_range(0, 7) == 0) begin
        start = 1; in_valid = 1; in_sad = {rand_sad(), rand_sad()}; in_tag_base = $urandom();
        @(posedge Clk); #1;
        start = 0; in_valid = 0;
      end else begin
        pulse_start();
      end
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        int r;
        idle($urandom_range(0, 2));
        r = $urandom_range(0, 29);
        if (r == 0) pulse_start();
        if (r == 1) begin
          pulse_reset();
          aborted = 1;
          break;
        end
        send_beat({rand_sad(), rand_sad()}, $urandom(), k == n - 1);
      end
      if (!aborted) begin
        if ($urandom_range(0, 5) == 0) pulse_reset();
        else idle($urandom_range(0, 4));
      end
    end

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
